// File: rtl/dtmf_pkg.sv
// rtl/dtmf_pkg.sv - shared DTMF tables, code/state enums and classification result type
package dtmf_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    // Nominal peak bins, index 0 first (rows 19,21,23,25 / columns 32,35,39,43).
    localparam logic [NUM_ROWS-1:0][7:0] ROW_BINS = {8'd25, 8'd23, 8'd21, 8'd19};
    localparam logic [NUM_COLS-1:0][7:0] COL_BINS = {8'd43, 8'd39, 8'd35, 8'd32};

    typedef enum logic [3:0] {
        KEY_0, KEY_1, KEY_2, KEY_3, KEY_4, KEY_5, KEY_6, KEY_7,
        KEY_8, KEY_9, KEY_A, KEY_B, KEY_C, KEY_D, KEY_STAR, KEY_HASH
    } dtmf_code_e;

    // Keypad layout indexed by {row, col}; row 0 is the top row "1 2 3 A".
    localparam logic [15:0][3:0] KEYPAD = {
        KEY_D, KEY_HASH, KEY_0, KEY_STAR,
        KEY_C, KEY_9,    KEY_8, KEY_7,
        KEY_B, KEY_6,    KEY_5, KEY_4,
        KEY_A, KEY_3,    KEY_2, KEY_1
    };

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } dtmf_class_t;

    // Result reported for frames that do not decode to exactly one key.
    localparam dtmf_class_t NO_TONE = '{hit: 1'b0, code: 4'd0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAND,
        ST_LOCK
    } dtmf_state_e;

    function automatic logic [3:0] keypad_code(input logic [1:0] row, input logic [1:0] col);
        return KEYPAD[{row, col}];
    endfunction

endpackage

// File: rtl/dtmf_bin_classifier.sv
// rtl/dtmf_bin_classifier.sv - combinational row/column bin match to keypad code
//   low_bin, high_bin : peak bin indices of the current frame
//   hit               : exactly one row and exactly one column within +/-TOL
//   code              : keypad code when hit, NO_TONE code otherwise
module dtmf_bin_classifier
    import dtmf_pkg::*;
#(
    parameter int BIN_W = 6,
    parameter int TOL   = 1
) (
    input  logic [BIN_W-1:0] low_bin,
    input  logic [BIN_W-1:0] high_bin,
    output logic             hit,
    output logic [3:0]       code
);

    // One extra bit keeps the difference unsigned and non-wrapping near bin 0.
    function automatic logic bin_near(input logic [BIN_W-1:0] bin, input logic [7:0] nominal);
        logic [BIN_W:0] a;
        logic [BIN_W:0] n;
        logic [BIN_W:0] d;
        a = {1'b0, bin};
        n = (BIN_W+1)'(nominal);
        d = (a >= n) ? (a - n) : (n - a);
        return d <= (BIN_W+1)'(TOL);
    endfunction

    logic [2:0] row_cnt;
    logic [2:0] col_cnt;
    logic [1:0] row_idx;
    logic [1:0] col_idx;

    always_comb begin
        row_cnt = '0;
        col_cnt = '0;
        row_idx = '0;
        col_idx = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (bin_near(low_bin, ROW_BINS[r])) begin
                row_cnt = row_cnt + 3'd1;
                row_idx = 2'(r);
            end
        end
        for (int c = 0; c < NUM_COLS; c++) begin
            if (bin_near(high_bin, COL_BINS[c])) begin
                col_cnt = col_cnt + 3'd1;
                col_idx = 2'(c);
            end
        end
    end

    // A bin sitting between two nominals matches both and is rejected as ambiguous.
    always_comb begin
        hit  = (row_cnt == 3'd1) && (col_cnt == 3'd1);
        code = hit ? keypad_code(row_idx, col_idx) : NO_TONE.code;
    end

endmodule

// File: rtl/dtmf_digit_decoder.sv
// rtl/dtmf_digit_decoder.sv - debounced DTMF digit decoder with valid/ready output (option: DTMF_ERR_CNT_EN)
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   : frame handshake; in_ready = ~out_valid | out_ready
//   low_bin, high_bin    : row / column peak bins of the frame
//   out_valid, out_ready : digit handshake, digit held until taken
//   out_code             : keypad code (0-9, A-D = 10-13, * = 14, # = 15)
//   err_count            : DTMF_ERR_CNT_EN only, saturating count of nonzero-bin NoTone frames
module dtmf_digit_decoder
    import dtmf_pkg::*;
#(
    parameter int BIN_W       = 6,
    parameter int TOL         = 1,
    parameter int HOLD_FRAMES = 2,
    parameter int GAP_FRAMES  = 1,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BIN_W-1:0] low_bin,
    input  logic [BIN_W-1:0] high_bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_code
`ifdef DTMF_ERR_CNT_EN
    ,
    output logic [7:0]       err_count
`endif
);

    logic        hit;
    logic [3:0]  code;

    dtmf_bin_classifier #(
        .BIN_W (BIN_W),
        .TOL   (TOL)
    ) u_classifier (
        .low_bin  (low_bin),
        .high_bin (high_bin),
        .hit      (hit),
        .code     (code)
    );

    dtmf_state_e      state, state_n;
    logic [3:0]       cand, cand_n;
    logic [CNT_W-1:0] hold, hold_n, hold_inc;
    logic [CNT_W-1:0] gap, gap_n, gap_inc;
    logic             emit;
    logic             accept;

    // A held digit stalls the frame stream rather than dropping frames.
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        hold_n   = hold;
        gap_n    = gap;
        emit     = 1'b0;
        hold_inc = hold + CNT_W'(1);
        gap_inc  = gap + CNT_W'(1);
        if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        cand_n = code;
                        hold_n = CNT_W'(1);
                        if (HOLD_FRAMES == 1) begin
                            emit    = 1'b1;
                            state_n = ST_LOCK;
                            hold_n  = '0;
                            gap_n   = '0;
                        end else begin
                            state_n = ST_CAND;
                        end
                    end
                end
                ST_CAND: begin
                    if (!hit) begin
                        state_n = ST_IDLE;
                        hold_n  = '0;
                    end else if (code == cand) begin
                        hold_n = hold_inc;
                        if (hold_inc == CNT_W'(HOLD_FRAMES)) begin
                            emit    = 1'b1;
                            state_n = ST_LOCK;
                            hold_n  = '0;
                            gap_n   = '0;
                        end
                    end else begin
                        cand_n = code;
                        hold_n = CNT_W'(1);
                    end
                end
                ST_LOCK: begin
                    // Any valid key keeps the lock; only a run of silent frames re-arms.
                    if (hit) begin
                        gap_n = '0;
                    end else if (gap_inc == CNT_W'(GAP_FRAMES)) begin
                        state_n = ST_IDLE;
                        gap_n   = '0;
                    end else begin
                        gap_n = gap_inc;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            cand      <= '0;
            hold      <= '0;
            gap       <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
        end else begin
            state <= state_n;
            cand  <= cand_n;
            hold  <= hold_n;
            gap   <= gap_n;
            if (emit) begin
                out_valid <= 1'b1;
                out_code  <= cand_n;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef DTMF_ERR_CNT_EN
    // All-zero bins mean the front end saw silence, which is not an error.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_count <= '0;
        end else if (accept && !hit && ((|low_bin) || (|high_bin)) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dtmf_digit_decoder.sv
// tb/tb_dtmf_digit_decoder.sv - self-checking bench for dtmf_digit_decoder
module tb_dtmf_digit_decoder;

    localparam int BIN_W = 6;
    localparam int TOL   = 1;
    localparam int HOLD  = 2;
    localparam int GAP   = 1;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [BIN_W-1:0] low_bin;
    logic [BIN_W-1:0] high_bin;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_code;
`ifdef DTMF_ERR_CNT_EN
    logic [7:0]       err_count;
`endif

    dtmf_digit_decoder #(
        .BIN_W       (BIN_W),
        .TOL         (TOL),
        .HOLD_FRAMES (HOLD),
        .GAP_FRAMES  (GAP),
        .CNT_W       (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .low_bin   (low_bin),
        .high_bin  (high_bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code)
`ifdef DTMF_ERR_CNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    int ROWS[4] = '{19, 21, 23, 25};
    int COLS[4] = '{32, 35, 39, 43};
    int KEYS[4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    function automatic int ref_classify(input int lo, input int hi);
        int nr, nc, rr, cc, d;
        nr = 0; nc = 0; rr = 0; cc = 0;
        for (int r = 0; r < 4; r++) begin
            d = lo - ROWS[r];
            if (d < 0) d = -d;
            if (d <= TOL) begin nr++; rr = r; end
        end
        for (int c = 0; c < 4; c++) begin
            d = hi - COLS[c];
            if (d < 0) d = -d;
            if (d <= TOL) begin nc++; cc = c; end
        end
        if (nr == 1 && nc == 1) return KEYS[rr][cc];
        return -1;
    endfunction

    // Reference behaviour: run length of identical keys, a lock flag and a silence run.
    bit m_started = 0;
    bit m_valid = 0;
    int m_code = 0;
    int m_run_code = 0;
    int m_run_len = 0;
    bit m_locked = 0;
    int m_gap = 0;
    int m_err = 0;
    int got[$];

    initial begin
        bit acc, emit;
        int k, e_code;
        forever begin
            @(negedge clock);
            if (m_started) begin
                check("in_ready", int'(in_ready), int'(!m_valid || out_ready));
                check("out_valid", int'(out_valid), int'(m_valid));
                check("out_code", int'(out_code), m_code);
`ifdef DTMF_ERR_CNT_EN
                check("err_count", int'(err_count), m_err);
`endif
                if (out_valid && out_ready) got.push_back(int'(out_code));
            end
            if (reset) begin
                m_started = 1; m_valid = 0; m_code = 0; m_run_len = 0;
                m_locked = 0; m_gap = 0; m_err = 0;
            end else if (m_started) begin
                acc = in_valid && (!m_valid || out_ready);
                emit = 0; e_code = 0;
                k = ref_classify(int'(low_bin), int'(high_bin));
                if (acc) begin
                    if (k >= 0) begin
                        if (m_locked) m_gap = 0;
                        else begin
                            if (m_run_len > 0 && k == m_run_code) m_run_len++;
                            else begin m_run_code = k; m_run_len = 1; end
                            if (m_run_len == HOLD) begin
                                emit = 1; e_code = k; m_locked = 1; m_run_len = 0; m_gap = 0;
                            end
                        end
                    end else begin
                        m_run_len = 0;
                        if (m_locked) begin
                            m_gap++;
                            if (m_gap == GAP) begin m_locked = 0; m_gap = 0; end
                        end
                        if ((low_bin != 0 || high_bin != 0) && m_err < 255) m_err++;
                    end
                end
                if (emit) begin m_valid = 1; m_code = e_code; end
                else if (m_valid && out_ready) m_valid = 0;
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic send(input int lo, input int hi);
        int n;
        in_valid = 1'b1;
        low_bin  = BIN_W'(lo);
        high_bin = BIN_W'(hi);
        n = 0;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clock); #1; end
    endtask

    int exp_codes[6] = '{6, 1, 1, 1, 13, 9};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; low_bin = '0; high_bin = '0;

        check("ref_21_39", ref_classify(21, 39), 6);
        check("ref_18_33", ref_classify(18, 33), 1);
        check("ref_24_33", ref_classify(24, 33), -1);
        check("ref_20_44", ref_classify(20, 44), -1);
        check("ref_25_43", ref_classify(25, 43), 13);
        check("ref_25_35", ref_classify(25, 35), 0);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_code", int'(out_code), 0);
        idle(2);

        // Row 21 / column 39 is key 6.
        send(21, 39);
        check("t1_no_emit_first", int'(out_valid), 0);
        send(21, 39);
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_latency_code", int'(out_code), 6);
        send(0, 0);

        send(18, 33); send(18, 33);
        send(24, 33);
        idle(2);

        repeat (5) send(19, 32);
        send(0, 0);
        send(19, 32); send(19, 32);
        send(0, 0);

        send(25, 35); send(25, 43); send(25, 43);
        send(0, 0);

        out_ready = 1'b0;
        send(23, 39); send(23, 39);
        in_valid = 1'b1; low_bin = '0; high_bin = '0;
        repeat (10) begin
            @(negedge clock);
            check("t5_stall_in_ready", int'(in_ready), 0);
            check("t5_stable_code", int'(out_code), 9);
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        @(negedge clock);
        check("t5_in_ready_back", int'(in_ready), 1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        idle(2);

        send(19, 32);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        send(23, 39);
        idle(3);
        check("t6_no_emit", int'(out_valid), 0);
        check("digit_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check($sformatf("digit_%0d", i), got[i], exp_codes[i]);

`ifdef DTMF_ERR_CNT_EN
        repeat (300) send(5, 5);
        idle(1);
        check("err_saturate", int'(err_count), 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
